// File: rtl/adder_share_arbiter_if.sv
// Requester-side bundle of the shared-adder arbiter: request handshake plus response pulse.
// The master modport is the requester side; the slave modport is the arbiter.
interface adder_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = 2
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;

    modport master (
        output req_valid, req_a, req_b, req_cin,
        input  req_ready, rsp_valid, rsp_id, rsp_sum
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin,
        output req_ready, rsp_valid, rsp_id, rsp_sum
    );
endinterface

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter time-sharing one external combinational adder among NREQ requesters.
// Two register stages: operand capture toward the adder, then sum capture into the response.
module adder_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int IDW   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    adder_share_arbiter_if.slave    bus,
    output logic [WIDTH-1:0]        add_a,
    output logic [WIDTH-1:0]        add_b,
    output logic                    add_cin,
    input  logic [WIDTH-1:0]        add_s
);

    logic [IDW-1:0] last_grant;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] sel;
    logic           grant_any;
    logic           transfer;
    logic           op_valid;
    logic [IDW-1:0] op_id;

    // The nearest valid requester after last_grant wins; later hits are ignored.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        grant_idx = '0;
        grant_any = 1'b0;
        sel       = '0;
        for (int k = 1; k <= NREQ; k++) begin
            sel = IDW'((int'(last_grant) + k) % NREQ);
            if (!grant_any && bus.req_valid[sel]) begin
                grant_any = 1'b1;
                grant_idx = sel;
            end
        end
    end

    assign transfer      = en && grant_any;
    assign bus.req_ready = transfer ? (NREQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            add_a      <= '0;
            add_b      <= '0;
            add_cin    <= 1'b0;
            op_valid   <= 1'b0;
            op_id      <= '0;
            last_grant <= IDW'(NREQ - 1);
        end else begin
            op_valid <= transfer;
            if (transfer) begin
                add_a      <= bus.req_a[int'(grant_idx)*WIDTH +: WIDTH];
                add_b      <= bus.req_b[int'(grant_idx)*WIDTH +: WIDTH];
                add_cin    <= bus.req_cin[grant_idx];
                op_id      <= grant_idx;
                last_grant <= grant_idx;
            end
        end
    end

    // Response stage: sum and id only move when a real operation is in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_sum   <= '0;
        end else begin
            bus.rsp_valid <= op_valid;
            if (op_valid) begin
                bus.rsp_sum <= add_s;
                bus.rsp_id  <= op_id;
            end
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Bench for adder_share_arbiter: directed vector table, hand sequences for rotation and
// mid-operation reset, then randomized traffic against a queue-based reference model.
module tb_adder_share_arbiter;
    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int IDW   = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             en = 1'b0;
    logic [WIDTH-1:0] add_a, add_b, add_s;
    logic             add_cin;

    adder_share_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) bus ();

    adder_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .bus     (bus),
        .add_a   (add_a),
        .add_b   (add_b),
        .add_cin (add_cin),
        .add_s   (add_s)
    );

    // The external shared adder.
    assign add_s = add_a + add_b + WIDTH'(add_cin);

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all(input logic e, input logic [NREQ-1:0] v, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic c);
        en = e;
        bus.req_valid = v;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*WIDTH +: WIDTH] = a;
            bus.req_b[i*WIDTH +: WIDTH] = b;
            bus.req_cin[i] = c;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_all(1'b0, '0, '0, '0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic             en;
        logic [NREQ-1:0]  valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [NREQ-1:0]  ready;
        logic             rv;
        logic [IDW-1:0]   id;
        logic [WIDTH-1:0] sum;
    } vec_t;

    localparam int NV = 17;
    vec_t tbl [NV];

    typedef struct {
        int               id;
        logic [WIDTH-1:0] sum;
        int               due;
    } exp_t;

    exp_t             sbq [$];
    logic             pend [NREQ];
    logic [WIDTH-1:0] ra [NREQ];
    logic [WIDTH-1:0] rb [NREQ];
    logic             rc [NREQ];

    initial begin
        // Directed table; operands broadcast to every requester, values hand-derived.
        tbl[0]  = '{1'b1, 4'b0001, 16'h1234, 16'h0101, 1'b0, 4'b0001, 1'b0, 2'd0, 16'h0000};
        tbl[1]  = '{1'b1, 4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd0, 16'h0000};
        tbl[2]  = '{1'b1, 4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 2'd0, 16'h1335};
        tbl[3]  = '{1'b1, 4'b0100, 16'hFFFF, 16'h0000, 1'b1, 4'b0100, 1'b0, 2'd0, 16'h1335};
        tbl[4]  = '{1'b1, 4'b0100, 16'h0001, 16'h7FFF, 1'b0, 4'b0100, 1'b0, 2'd0, 16'h1335};
        tbl[5]  = '{1'b1, 4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h0000};
        tbl[6]  = '{1'b1, 4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h8000};
        tbl[7]  = '{1'b1, 4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd2, 16'h8000};
        tbl[8]  = '{1'b0, 4'b1111, 16'h0010, 16'h0020, 1'b0, 4'b0000, 1'b0, 2'd2, 16'h8000};
        tbl[9]  = '{1'b0, 4'b1111, 16'h0010, 16'h0020, 1'b0, 4'b0000, 1'b0, 2'd2, 16'h8000};
        tbl[10] = '{1'b1, 4'b1111, 16'h0010, 16'h0020, 1'b0, 4'b1000, 1'b0, 2'd2, 16'h8000};
        tbl[11] = '{1'b1, 4'b0111, 16'h0010, 16'h0020, 1'b0, 4'b0001, 1'b0, 2'd2, 16'h8000};
        tbl[12] = '{1'b1, 4'b0110, 16'h0010, 16'h0020, 1'b0, 4'b0010, 1'b1, 2'd3, 16'h0030};
        tbl[13] = '{1'b1, 4'b0100, 16'h0010, 16'h0020, 1'b0, 4'b0100, 1'b1, 2'd0, 16'h0030};
        tbl[14] = '{1'b1, 4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 2'd1, 16'h0030};
        tbl[15] = '{1'b1, 4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 2'd2, 16'h0030};
        tbl[16] = '{1'b1, 4'b0000, 16'h0000, 16'h0000, 1'b0, 4'b0000, 1'b0, 2'd2, 16'h0030};

        do_reset();
        @(negedge clk);
        check("reset.add_a", 32'(add_a), 32'h0);
        check("reset.add_b", 32'(add_b), 32'h0);
        check("reset.add_cin", 32'(add_cin), 32'h0);
        check("reset.rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset.rsp_id", 32'(bus.rsp_id), 32'h0);
        check("reset.rsp_sum", 32'(bus.rsp_sum), 32'h0);
        check("reset.req_ready", 32'(bus.req_ready), 32'h0);
        tick();

        for (int i = 0; i < NV; i++) begin
            drive_all(tbl[i].en, tbl[i].valid, tbl[i].a, tbl[i].b, tbl[i].cin);
            @(negedge clk);
            check($sformatf("tbl[%0d].req_ready", i), 32'(bus.req_ready), 32'(tbl[i].ready));
            check($sformatf("tbl[%0d].rsp_valid", i), 32'(bus.rsp_valid), 32'(tbl[i].rv));
            check($sformatf("tbl[%0d].rsp_id", i), 32'(bus.rsp_id), 32'(tbl[i].id));
            check($sformatf("tbl[%0d].rsp_sum", i), 32'(bus.rsp_sum), 32'(tbl[i].sum));
            tick();
        end

        // All four held valid for eight cycles: strict rotation, one response per cycle.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            en = 1'b1;
            bus.req_valid = (k < 8) ? 4'b1111 : 4'b0000;
            for (int i = 0; i < NREQ; i++) begin
                bus.req_a[i*WIDTH +: WIDTH] = WIDTH'(16'h1000 * i + 1);
                bus.req_b[i*WIDTH +: WIDTH] = WIDTH'(i);
                bus.req_cin[i] = 1'(i % 2);
            end
            @(negedge clk);
            check($sformatf("rot[%0d].req_ready", k), 32'(bus.req_ready),
                  (k < 8) ? (32'h1 << (k % 4)) : 32'h0);
            check($sformatf("rot[%0d].rsp_valid", k), 32'(bus.rsp_valid), (k >= 2) ? 32'h1 : 32'h0);
            if (k >= 2) begin
                check($sformatf("rot[%0d].rsp_id", k), 32'(bus.rsp_id), 32'((k - 2) % 4));
                check($sformatf("rot[%0d].rsp_sum", k), 32'(bus.rsp_sum),
                      32'(16'h1000 * ((k - 2) % 4) + 1 + ((k - 2) % 4) + ((k - 2) % 2)));
            end
            tick();
        end

        // Reset asserted in the cycle after a transfer drops the in-flight operation.
        do_reset();
        drive_all(1'b1, 4'b0010, 16'h5555, 16'h1111, 1'b1);
        @(negedge clk);
        check("rstmid.grant", 32'(bus.req_ready), 32'h2);
        tick();
        drive_all(1'b1, 4'b0000, 16'h0, 16'h0, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        check("rstmid.add_a", 32'(add_a), 32'h0);
        check("rstmid.add_b", 32'(add_b), 32'h0);
        check("rstmid.add_cin", 32'(add_cin), 32'h0);
        check("rstmid.rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rstmid.rsp_sum", 32'(bus.rsp_sum), 32'h0);
        check("rstmid.rsp_id", 32'(bus.rsp_id), 32'h0);
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check($sformatf("rstmid.quiet[%0d]", k), 32'(bus.rsp_valid), 32'h0);
            tick();
        end
        drive_all(1'b1, 4'b1111, 16'h0, 16'h0, 1'b0);
        @(negedge clk);
        check("rstmid.first_grant", 32'(bus.req_ready), 32'h1);
        tick();

        // Randomized traffic against a reference model of the arbitration rules.
        begin
            int               model_last;
            int               cyc;
            int               g;
            logic             any;
            logic [WIDTH-1:0] last_sum;
            logic [NREQ-1:0]  exp_ready;

            do_reset();
            model_last = NREQ - 1;
            last_sum   = '0;
            sbq.delete();
            for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;

            for (cyc = 0; cyc < 10000; cyc++) begin
                bool_drive: begin
                    for (int i = 0; i < NREQ; i++) begin
                        if (cyc < 9995 && !pend[i] && $urandom_range(0, 1) == 1) begin
                            pend[i] = 1'b1;
                            ra[i] = WIDTH'($urandom);
                            rb[i] = WIDTH'($urandom);
                            rc[i] = 1'($urandom);
                        end
                        bus.req_valid[i] = pend[i];
                        bus.req_a[i*WIDTH +: WIDTH] = ra[i];
                        bus.req_b[i*WIDTH +: WIDTH] = rb[i];
                        bus.req_cin[i] = rc[i];
                    end
                    en = ($urandom_range(0, 7) != 0);
                end

                @(negedge clk);
                g = -1;
                any = 1'b0;
                for (int k = 1; k <= NREQ; k++) begin
                    if (!any && pend[(model_last + k) % NREQ]) begin
                        any = 1'b1;
                        g = (model_last + k) % NREQ;
                    end
                end
                exp_ready = (en && any) ? NREQ'(1 << g) : '0;
                check("rnd.req_ready", 32'(bus.req_ready), 32'(exp_ready));

                if (sbq.size() > 0 && sbq[0].due == cyc) begin
                    check("rnd.rsp_valid", 32'(bus.rsp_valid), 32'h1);
                    check("rnd.rsp_id", 32'(bus.rsp_id), 32'(sbq[0].id));
                    check("rnd.rsp_sum", 32'(bus.rsp_sum), 32'(sbq[0].sum));
                    last_sum = sbq[0].sum;
                    void'(sbq.pop_front());
                end else begin
                    check("rnd.rsp_idle", 32'(bus.rsp_valid), 32'h0);
                    check("rnd.rsp_hold", 32'(bus.rsp_sum), 32'(last_sum));
                end

                if (en && any) begin
                    sbq.push_back('{g, WIDTH'(32'(ra[g]) + 32'(rb[g]) + 32'(rc[g])), cyc + 2});
                    pend[g] = 1'b0;
                    model_last = g;
                end
                tick();
            end
            check("rnd.drained", 32'(sbq.size()), 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
